hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It sits beside the register file's read side and tracks every in-flight register write (destination, write-enable, remaining result latency) through the E, M and W stages. From that tracking it drives a D-stage stall and the forwarding selects for every register operand read in D, E and M. Register-file internal bypass covers W→D, so this block never forwards into D from W.

---
 rtl/mips_pkg.sv | 50 +++++
 rtl/hazard_stage_reg.sv | 79 +++++++
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core's hazard logic.
// Holds the forward-select encoding, Tnew/Tuse constants, the stage-entry layout and
// small helpers used by the hazard controller's match and priority logic.
package mips_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned TNEW_W_DEF = 2;

  // Forward select encoding
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_E    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_W    = 2'b11;

  // Result latency measured at E entry
  localparam logic [TNEW_W_DEF-1:0] TNEW_LINK = 2'd0;
  localparam logic [TNEW_W_DEF-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W_DEF-1:0] TNEW_LOAD = 2'd2;

  // Tuse value meaning the operand is not read at all
  localparam logic [TNEW_W_DEF-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic                  valid;
    logic [REG_W-1:0]      a3;
    logic                  we;
    logic [TNEW_W_DEF-1:0] tnew;
    logic [REG_W-1:0]      rs;
    logic [REG_W-1:0]      rt;
  } stage_t;

  // An in-flight entry is live for r when it will write r; $0 never matches.
  function automatic logic is_live(logic valid, logic we, logic [REG_W-1:0] a3,
                                   logic [REG_W-1:0] r);
    return valid && we && (a3 == r) && (r != '0);
  endfunction

  // Nearest-first select: a live-but-not-ready near producer blocks the older one.
  function automatic logic [1:0] pick_fwd(logic live_near, logic rdy_near, logic [1:0] sel_near,
                                          logic live_far, logic rdy_far, logic [1:0] sel_far);
    if (live_near) begin
      return rdy_near ? sel_near : FWD_NONE;
    end
    if (live_far && rdy_far) begin
      return sel_far;
    end
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline tracking entry (valid, a3, we, tnew, rs, rt) for the hazard controller.
// Ports: clk_i/rst_ni (synchronous, active low), bubble_i loads an empty entry,
// *_i next-stage fields, *_o current entry. DecTnew selects saturating tnew decrement on load.
module hazard_stage_reg
  import mips_pkg::*;
#(
  parameter int unsigned TNEW_W  = 2,
  parameter bit          DecTnew = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  logic [REG_W-1:0]  a3_i,
  input  logic              we_i,
  input  logic [TNEW_W-1:0] tnew_i,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  output logic              valid_o,
  output logic [REG_W-1:0]  a3_o,
  output logic              we_o,
  output logic [TNEW_W-1:0] tnew_o,
  output logic [REG_W-1:0]  rs_o,
  output logic [REG_W-1:0]  rt_o
);

  logic              valid_d, valid_q;
  logic [REG_W-1:0]  a3_d, a3_q;
  logic              we_d, we_q;
  logic [TNEW_W-1:0] tnew_d, tnew_q;
  logic [REG_W-1:0]  rs_d, rs_q;
  logic [REG_W-1:0]  rt_d, rt_q;

  always_comb begin
    valid_d = valid_i;
    a3_d    = a3_i;
    we_d    = we_i;
    tnew_d  = tnew_i;
    rs_d    = rs_i;
    rt_d    = rt_i;
    if (DecTnew && (tnew_i != '0)) begin
      tnew_d = tnew_i - TNEW_W'(1);
    end
    if (bubble_i) begin
      valid_d = 1'b0;
      a3_d    = '0;
      we_d    = 1'b0;
      tnew_d  = '0;
      rs_d    = '0;
      rt_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      a3_q    <= '0;
      we_q    <= 1'b0;
      tnew_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else begin
      valid_q <= valid_d;
      a3_q    <= a3_d;
      we_q    <= we_d;
      tnew_q  <= tnew_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
    end
  end

  assign valid_o = valid_q;
  assign a3_o    = a3_q;
  assign we_o    = we_q;
  assign tnew_o  = tnew_q;
  assign rs_o    = rs_q;
  assign rt_o    = rt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight GRF writes through E, M and W and drives the
// D-stage stall plus forwarding selects for D, E and M operand reads.
// Ports: clk, reset (synchronous, active low); D-stage rs/rt/Tuse, a3/we/tnew, md_D, mdu_busy;
// outputs stall and fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M (all combinational).
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  rs_D,
  input  logic [REG_W-1:0]  rt_D,
  input  logic [TNEW_W-1:0] tuse_rs_D,
  input  logic [TNEW_W-1:0] tuse_rt_D,
  input  logic [REG_W-1:0]  a3_D,
  input  logic              we_D,
  input  logic [TNEW_W-1:0] tnew_D,
  input  logic              md_D,
  input  logic              mdu_busy,
  output logic              stall,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic [1:0]        fwd_rt_M
);

  localparam logic [TNEW_W-1:0] TuseNoneW = TNEW_W'(TUSE_NONE);

  logic              e_valid, m_valid, w_valid;
  logic [REG_W-1:0]  e_a3, m_a3, w_a3;
  logic              e_we, m_we, w_we;
  logic [TNEW_W-1:0] e_tnew, m_tnew, w_tnew;
  logic [REG_W-1:0]  e_rs, m_rs, w_rs;
  logic [REG_W-1:0]  e_rt, m_rt, w_rt;
  logic              stall_raw;

  hazard_stage_reg #(.TNEW_W(TNEW_W), .DecTnew(1'b0)) u_stage_e (
    .clk_i(clk), .rst_ni(reset), .bubble_i(stall_raw),
    .valid_i(1'b1), .a3_i(a3_D), .we_i(we_D), .tnew_i(tnew_D), .rs_i(rs_D), .rt_i(rt_D),
    .valid_o(e_valid), .a3_o(e_a3), .we_o(e_we), .tnew_o(e_tnew), .rs_o(e_rs), .rt_o(e_rt)
  );

  hazard_stage_reg #(.TNEW_W(TNEW_W), .DecTnew(1'b1)) u_stage_m (
    .clk_i(clk), .rst_ni(reset), .bubble_i(1'b0),
    .valid_i(e_valid), .a3_i(e_a3), .we_i(e_we), .tnew_i(e_tnew), .rs_i(e_rs), .rt_i(e_rt),
    .valid_o(m_valid), .a3_o(m_a3), .we_o(m_we), .tnew_o(m_tnew), .rs_o(m_rs), .rt_o(m_rt)
  );

  hazard_stage_reg #(.TNEW_W(TNEW_W), .DecTnew(1'b1)) u_stage_w (
    .clk_i(clk), .rst_ni(reset), .bubble_i(1'b0),
    .valid_i(m_valid), .a3_i(m_a3), .we_i(m_we), .tnew_i(m_tnew), .rs_i(m_rs), .rt_i(m_rt),
    .valid_o(w_valid), .a3_o(w_a3), .we_o(w_we), .tnew_o(w_tnew), .rs_o(w_rs), .rt_o(w_rt)
  );

  // Operand numbers of the W entry are never read again.
  logic unused_w_regs;
  assign unused_w_regs = ^{w_rs, w_rt};

  logic e_rdy, m_rdy, w_rdy;
  assign e_rdy = (e_tnew == '0);
  assign m_rdy = (m_tnew == '0);
  assign w_rdy = (w_tnew == '0);

  logic rs_d_e, rs_d_m, rt_d_e, rt_d_m;
  logic rs_e_m, rs_e_w, rt_e_m, rt_e_w, rt_m_w;
  assign rs_d_e = is_live(e_valid, e_we, e_a3, rs_D);
  assign rs_d_m = is_live(m_valid, m_we, m_a3, rs_D);
  assign rt_d_e = is_live(e_valid, e_we, e_a3, rt_D);
  assign rt_d_m = is_live(m_valid, m_we, m_a3, rt_D);
  assign rs_e_m = is_live(m_valid, m_we, m_a3, e_rs);
  assign rs_e_w = is_live(w_valid, w_we, w_a3, e_rs);
  assign rt_e_m = is_live(m_valid, m_we, m_a3, e_rt);
  assign rt_e_w = is_live(w_valid, w_we, w_a3, e_rt);
  assign rt_m_w = is_live(w_valid, w_we, w_a3, m_rt);

  // Producer result arrives later than the reader needs it.
  function automatic logic too_late(logic live, logic [TNEW_W-1:0] tnew,
                                    logic [TNEW_W-1:0] tuse);
    return live && (tuse != TuseNoneW) && (tnew > tuse);
  endfunction

  assign stall_raw = (md_D & mdu_busy)
                   | too_late(rs_d_e, e_tnew, tuse_rs_D) | too_late(rs_d_m, m_tnew, tuse_rs_D)
                   | too_late(rt_d_e, e_tnew, tuse_rt_D) | too_late(rt_d_m, m_tnew, tuse_rt_D);

  // Outputs are forced to zero while reset is asserted, even before state has been cleared.
  assign stall    = reset & stall_raw;
  assign fwd_rs_D = reset ? pick_fwd(rs_d_e, e_rdy, FWD_E, rs_d_m, m_rdy, FWD_M) : FWD_NONE;
  assign fwd_rt_D = reset ? pick_fwd(rt_d_e, e_rdy, FWD_E, rt_d_m, m_rdy, FWD_M) : FWD_NONE;
  assign fwd_rs_E = reset ? pick_fwd(rs_e_m, m_rdy, FWD_M, rs_e_w, w_rdy, FWD_W) : FWD_NONE;
  assign fwd_rt_E = reset ? pick_fwd(rt_e_m, m_rdy, FWD_M, rt_e_w, w_rdy, FWD_W) : FWD_NONE;
  assign fwd_rt_M = reset ? pick_fwd(rt_m_w, w_rdy, FWD_W, 1'b0, 1'b0, FWD_NONE) : FWD_NONE;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: short instruction sequences with
// hand-computed stall and forward-select values at each cycle.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic       we_D, md_D, mdu_busy;
  logic       stall;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.TNEW_W(2)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_D(a3_D), .we_D(we_D), .tnew_D(tnew_D), .md_D(md_D), .mdu_busy(mdu_busy),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] tu_rs, input logic [4:0] rt,
                       input logic [1:0] tu_rt, input logic [4:0] a3, input logic we,
                       input logic [1:0] tnew, input logic md);
    rs_D = rs; tuse_rs_D = tu_rs; rt_D = rt; tuse_rt_D = tu_rt;
    a3_D = a3; we_D = we; tnew_D = tnew; md_D = md;
    #1;
  endtask

  task automatic nop();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    mdu_busy = 1'b0;
    // Reset held with a writer of $5 and a reader of $5 in D
    #2;
    set_d(5'd5, 2'd1, 5'd5, 2'd1, 5'd5, 1'b1, 2'd1, 1'b0);
    check("rst_stall", {3'b0, stall}, 4'd0);
    check("rst_fwd_rs_D", {2'b0, fwd_rs_D}, 4'd0);
    check("rst_fwd_rt_M", {2'b0, fwd_rt_M}, 4'd0);
    tick();
    tick();
    check("rst_fwd_rs_E", {2'b0, fwd_rs_E}, 4'd0);
    check("rst_fwd_rt_E", {2'b0, fwd_rt_E}, 4'd0);
    reset = 1'b1;
    set_d(5'd5, 2'd1, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0);
    check("post_rst_stall", {3'b0, stall}, 4'd0);
    check("post_rst_fwd_rs_D", {2'b0, fwd_rs_D}, 4'd0);
    tick();
    nop();
    check("post_rst_fwd_rs_E", {2'b0, fwd_rs_E}, 4'd0);

    // Load-use: lw $8 then addu rs=$8 (Tuse 1)
    set_d(5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0);
    check("lw_issue_stall", {3'b0, stall}, 4'd0);
    tick();
    set_d(5'd8, 2'd1, 5'd0, 2'd1, 5'd10, 1'b1, 2'd1, 1'b0);
    check("lu_stall_1", {3'b0, stall}, 4'd1);
    check("lu_fwd_rs_D_blk", {2'b0, fwd_rs_D}, 4'd0);
    tick();
    check("lu_stall_2", {3'b0, stall}, 4'd0);
    check("lu_fwd_rs_D_notrdy", {2'b0, fwd_rs_D}, 4'd0);
    tick();
    nop();
    check("lu_fwd_rs_E", {2'b0, fwd_rs_E}, 4'd3);

    // ALU -> branch: addu $9 then beq rs=$9 (Tuse 0)
    set_d(5'd0, 2'd1, 5'd0, 2'd1, 5'd9, 1'b1, 2'd1, 1'b0);
    check("addu_issue_stall", {3'b0, stall}, 4'd0);
    tick();
    set_d(5'd9, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);
    check("br_stall_1", {3'b0, stall}, 4'd1);
    tick();
    check("br_stall_2", {3'b0, stall}, 4'd0);
    check("br_fwd_rs_D", {2'b0, fwd_rs_D}, 4'd2);
    tick();

    // jal -> jr $31
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 1'b1, 2'd0, 1'b0);
    tick();
    set_d(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0);
    check("jr_stall", {3'b0, stall}, 4'd0);
    check("jr_fwd_rs_D", {2'b0, fwd_rs_D}, 4'd1);
    tick();

    // $0 never matches: load to $0, then a reader of $0 with Tuse 0
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b1, 2'd2, 1'b0);
    check("jr_fwd_rs_E_from_M", {2'b0, fwd_rs_E}, 4'd2);
    tick();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);
    check("r0_stall", {3'b0, stall}, 4'd0);
    check("r0_fwd_rs_D", {2'b0, fwd_rs_D}, 4'd0);
    check("r0_fwd_rt_D", {2'b0, fwd_rt_D}, 4'd0);
    tick();

    // $7 written in M (older) and E (tnew 0): E wins
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 1'b1, 2'd1, 1'b0);
    tick();
    set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 1'b1, 2'd0, 1'b0);
    tick();
    set_d(5'd7, 2'd1, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0);
    check("prio_stall", {3'b0, stall}, 4'd0);
    check("prio_fwd_rs_D", {2'b0, fwd_rs_D}, 4'd1);
    tick();

    // MDU busy for 5 cycles; the md instruction reads $7, so a missing bubble would forward
    set_d(5'd7, 2'd1, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1);
    mdu_busy = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("md_stall_%0d", i), {3'b0, stall}, 4'd1);
      if (i > 0) check($sformatf("md_bubble_%0d", i), {2'b0, fwd_rs_E}, 4'd0);
      tick();
    end
    mdu_busy = 1'b0;
    // Writer of $4 (ALU) then a store of $4
    set_d(5'd0, 2'd1, 5'd0, 2'd3, 5'd4, 1'b1, 2'd1, 1'b0);
    check("md_stall_end", {3'b0, stall}, 4'd0);
    check("md_bubble_5", {2'b0, fwd_rs_E}, 4'd0);
    tick();
    set_d(5'd0, 2'd1, 5'd4, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0);
    check("sw_stall", {3'b0, stall}, 4'd0);
    tick();
    nop();
    check("sw_fwd_rt_E", {2'b0, fwd_rt_E}, 4'd2);
    tick();
    check("sw_fwd_rt_M", {2'b0, fwd_rt_M}, 4'd3);

    // Reset during a load-use stall
    set_d(5'd0, 2'd1, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0);
    tick();
    set_d(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 1'b1, 2'd1, 1'b0);
    check("mid_rst_stall_pre", {3'b0, stall}, 4'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_stall_low", {3'b0, stall}, 4'd0);
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_stall_after", {3'b0, stall}, 4'd0);
    check("mid_rst_fwd_rs_D", {2'b0, fwd_rs_D}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
